// File: rtl/core_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: instruction word, decoder branch codes,
// FSM state encoding and reset defaults.
package core_sequencer_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef logic [31:0] instruction;

    typedef enum logic [1:0] {
        NO_JUMP = 2'd0,
        BEQ     = 2'd1,
        BLT     = 2'd2
    } ctrBranch;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } seq_state_e;

    function automatic logic branch_taken(input ctrBranch br, input logic zero, input logic neg);
        return ((br == BEQ) && zero) || ((br == BLT) && neg);
    endfunction

endpackage

// File: rtl/core_sequencer_pc_unit.sv
// PC register with next-PC adder/mux; only aligned targets are committed on retire.
module pc_unit
    import core_sequencer_pkg::*;
#(
    parameter int unsigned       XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            taken,
    input  logic [XLEN-1:0] offset,
    input  logic            retire,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        next_pc    = taken ? (pc_q + offset) : (pc_q + XLEN'(4));
        misaligned = (next_pc[1:0] != 2'b00);
        pc_d       = (retire && !misaligned) ? next_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch handshake, decode latch, execute, memory, writeback,
// retirement bookkeeping and sticky misaligned-target halt.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned       XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output instruction      insn,
    input  logic            dec_rwe,
    input  logic            dec_dwe,
    input  logic            dec_regSelect,
    input  ctrBranch        dec_branch,
    input  logic [XLEN-1:0] dec_offset,
    input  logic            alu_zero,
    input  logic            alu_neg,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instret,
    output logic            fault
);

    seq_state_e      state_q, state_d;
    instruction      insn_q;
    logic            rwe_q, dwe_q, rsel_q;
    ctrBranch        branch_q;
    logic [XLEN-1:0] offset_q;
    logic            taken_q;
    logic [31:0]     instret_q;
    logic            fault_q;

    logic            taken_now;
    logic            pc_taken;
    logic            is_load;
    logic            retire;
    logic            misaligned;

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        taken_now = branch_taken(branch_q, alu_zero, alu_neg);
        is_load   = rwe_q && !rsel_q && !dwe_q;
        // Flags are only live in EXECUTE; later retirements use the latched decision.
        pc_taken  = (state_q == EXECUTE) ? taken_now : taken_q;

        case (state_q)
            FETCH:   if (imem_ready) state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: begin
                if (dwe_q || is_load) state_d = MEM;
                else if (rwe_q)       state_d = WB;
                else                  retire  = 1'b1;
            end
            MEM: begin
                if (dmem_ready) begin
                    if (is_load) state_d = WB;
                    else         retire  = 1'b1;
                end
            end
            WB:      retire  = 1'b1;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        if (retire) state_d = misaligned ? HALT : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            insn_q    <= '0;
            rwe_q     <= 1'b0;
            dwe_q     <= 1'b0;
            rsel_q    <= 1'b0;
            branch_q  <= NO_JUMP;
            offset_q  <= '0;
            taken_q   <= 1'b0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ready) insn_q <= imem_rdata;
            if (state_q == DECODE) begin
                rwe_q    <= dec_rwe;
                dwe_q    <= dec_dwe;
                rsel_q   <= dec_regSelect;
                branch_q <= dec_branch;
                offset_q <= dec_offset;
            end
            if (state_q == EXECUTE) taken_q <= taken_now;
            if (retire && !misaligned) instret_q <= instret_q + 32'd1;
            if (retire && misaligned)  fault_q   <= 1'b1;
        end
    end

    pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .taken      (pc_taken),
        .offset     (offset_q),
        .retire     (retire),
        .pc         (pc),
        .misaligned (misaligned)
    );

    // Reset state is FETCH, so the fetch request is qualified to stay low while held in reset.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state_q == MEM);
    assign dmem_we   = (state_q == MEM) && dwe_q;
    assign rf_we     = (state_q == WB);
    assign insn      = insn_q;
    assign instret   = instret_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle output
// timeline from the latency rules; a compare process checks every cycle against it.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, dmem_req, dmem_we, rf_we, fault;
    logic [31:0] imem_addr, pc, instret;
    instruction  insn;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_rwe = 1'b0, dec_dwe = 1'b0, dec_regSelect = 1'b0;
    ctrBranch    dec_branch = NO_JUMP;
    logic [31:0] dec_offset = '0;
    logic        alu_zero = 1'b0, alu_neg = 1'b0;

    core_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .insn(insn),
        .dec_rwe(dec_rwe), .dec_dwe(dec_dwe), .dec_regSelect(dec_regSelect),
        .dec_branch(dec_branch), .dec_offset(dec_offset),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc(pc), .instret(instret), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] insn;
    } exp_t;

    exp_t expq[$];
    exp_t ce;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Architectural model state
    logic [31:0] mpc = '0, minstret = '0, minsn = '0;
    logic        mfault = 1'b0;

    // Staged inputs applied for the next cycle
    logic        s_iready, s_dready, s_rwe, s_dwe, s_rs, s_zero, s_neg;
    logic [31:0] s_rdata, s_off;
    ctrBranch    s_br;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic exp_t mk(input logic ir, input logic dr, input logic dw, input logic rw);
        exp_t e;
        e.imem_req = ir;
        e.dmem_req = dr;
        e.dmem_we  = dw;
        e.rf_we    = rw;
        e.fault    = mfault;
        e.pc       = mpc;
        e.instret  = minstret;
        e.insn     = minsn;
        return e;
    endfunction

    task automatic scramble();
        s_iready = 1'($urandom);
        s_dready = 1'($urandom);
        s_rwe    = 1'($urandom);
        s_dwe    = 1'($urandom);
        s_rs     = 1'($urandom);
        s_zero   = 1'($urandom);
        s_neg    = 1'($urandom);
        s_rdata  = $urandom;
        s_off    = $urandom;
        s_br     = ctrBranch'($urandom_range(0, 2));
    endtask

    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        imem_ready    = s_iready;
        dmem_ready    = s_dready;
        imem_rdata    = s_rdata;
        dec_rwe       = s_rwe;
        dec_dwe       = s_dwe;
        dec_regSelect = s_rs;
        dec_branch    = s_br;
        dec_offset    = s_off;
        alu_zero      = s_zero;
        alu_neg       = s_neg;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            ce = expq.pop_front();
            chk("imem_req",  32'(imem_req), 32'(ce.imem_req));
            chk("imem_addr", imem_addr,      ce.pc);
            chk("dmem_req",  32'(dmem_req), 32'(ce.dmem_req));
            chk("dmem_we",   32'(dmem_we),  32'(ce.dmem_we));
            chk("rf_we",     32'(rf_we),    32'(ce.rf_we));
            chk("pc",        pc,             ce.pc);
            chk("instret",   instret,        ce.instret);
            chk("fault",     32'(fault),    32'(ce.fault));
            chk("insn",      insn,           ce.insn);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        mpc = '0; minstret = '0; minsn = '0; mfault = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 branch/NOP. abort_mem drops reset during the MEM wait.
    task automatic run_insn(input int kind, input ctrBranch br, input logic [31:0] off,
                            input logic z, input logic n, input int iw, input int dw,
                            input bit abort_mem);
        logic        rwe, dwe, rs, load, taken;
        logic [31:0] word, nxt;
        rwe = (kind == 0) || (kind == 1);
        dwe = (kind == 2);
        rs  = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom);
        word = $urandom;
        for (int i = 0; i <= iw; i++) begin
            scramble();
            s_iready = (i == iw);
            s_rdata  = word;
            cyc(mk(1'b1, 1'b0, 1'b0, 1'b0));
        end
        minsn = word;
        scramble();
        s_rwe = rwe; s_dwe = dwe; s_rs = rs; s_br = br; s_off = off;
        cyc(mk(1'b0, 1'b0, 1'b0, 1'b0));
        scramble();
        s_zero = z; s_neg = n;
        cyc(mk(1'b0, 1'b0, 1'b0, 1'b0));
        taken = ((br == BEQ) && z) || ((br == BLT) && n);
        nxt   = taken ? mpc + off : mpc + 32'd4;
        load  = rwe && !rs && !dwe;
        if (dwe || load) begin
            for (int i = 0; i <= dw; i++) begin
                scramble();
                s_dready = (i == dw);
                if (abort_mem && i == 1) s_dready = 1'b0;
                cyc(mk(1'b0, 1'b1, dwe, 1'b0));
                if (abort_mem && i == 1) begin
                    @(negedge clk);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
                    chk("abort_imem_req", 32'(imem_req), 32'd0);
                    chk("abort_pc",       pc,            32'h0);
                    imem_ready = 1'b0;
                    dmem_ready = 1'b0;
                    mpc = '0; minstret = '0; minsn = '0; mfault = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    #1;
                    chk("first_fetch_addr", imem_addr, 32'h0);
                    return;
                end
            end
        end
        if (load || (rwe && !dwe)) begin
            scramble();
            cyc(mk(1'b0, 1'b0, 1'b0, 1'b1));
        end
        if (nxt[1:0] != 2'b00) mfault = 1'b1;
        else begin
            mpc      = nxt;
            minstret = minstret + 32'd1;
        end
    endtask

    // One cycle after retirement; in FETCH keep imem_ready low so nothing is accepted.
    task automatic idle();
        scramble();
        if (!mfault) s_iready = 1'b0;
        cyc(mk(!mfault, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        scramble();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_pc",       pc,            32'h0);
        chk("rst_instret",  instret,       32'd0);
        chk("rst_insn",     insn,          32'd0);
        chk("rst_fault",    32'(fault),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_insn(0, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        idle();
        chk("add_pc", pc, 32'h4);
        chk("add_instret", instret, 32'd1);
        run_insn(1, NO_JUMP, 32'd0, 1'b0, 1'b0, 1, 3, 1'b0);
        idle();
        chk("lw_pc", pc, 32'h8);
        run_insn(2, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_insn(3, NO_JUMP, 32'd0, 1'b1, 1'b1, 0, 0, 1'b0);
        idle();
        chk("nop_pc", pc, 32'h10);
        run_insn(3, BEQ, 32'hFFFF_FFF8, 1'b1, 1'b0, 0, 0, 1'b0);
        idle();
        chk("beq_pc", pc, 32'h08);
        run_insn(3, BLT, 32'h40, 1'b1, 1'b0, 0, 0, 1'b0);
        idle();
        chk("blt_pc", pc, 32'h0C);
        chk("blt_instret", instret, 32'd6);

        for (int k = 0; k < 150; k++) begin
            int          kind;
            logic [31:0] off;
            kind = $urandom_range(0, 3);
            off  = 32'($signed($urandom_range(0, 32)) - 16) <<< 2;
            run_insn(kind, ctrBranch'($urandom_range(0, 2)), off, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
        end

        do_reset();
        run_insn(3, BEQ, 32'hFFFF_FFFC, 1'b1, 1'b0, 0, 0, 1'b0);
        idle();
        chk("wrap_back_pc", pc, 32'hFFFF_FFFC);
        run_insn(3, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        idle();
        chk("wrap_fwd_pc", pc, 32'h0);
        chk("wrap_instret", instret, 32'd2);

        run_insn(3, BLT, 32'h6, 1'b0, 1'b1, 0, 0, 1'b0);
        repeat (4) idle();
        chk("halt_fault", 32'(fault), 32'd1);
        chk("halt_imem_req", 32'(imem_req), 32'd0);
        chk("halt_pc", pc, 32'h0);
        chk("halt_instret", instret, 32'd2);
        do_reset();
        #1;
        chk("clr_fault", 32'(fault), 32'd0);

        run_insn(0, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_insn(2, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 5, 1'b1);
        run_insn(3, NO_JUMP, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        idle();
        chk("post_abort_pc", pc, 32'h4);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
